// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit for the eMIPS3 pipeline.
// Turns one ID/EX memory operation into an SRAM-like bus access and stalls
// the pipeline until the access finishes. Load data returned by the bus is
// aligned and sign- or zero-extended for write-back.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word
// accesses with adel/ades. When it is undefined, misaligned accesses go to
// the bus unmodified.
module mem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ext_op,
  input  logic [4:0]  req_dst,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_dst,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic [2:0]  ext_op_q;
  logic [4:0]  dst_q;
  logic [1:0]  size_q, req_size;
  logic        wr_q, killed_q;
  logic        accept, launch, complete, kill_now, suppressed, misaligned;

  // Bus size code: stores follow the number of enabled lanes, loads the ext code.
  function automatic logic [1:0] size_of(input logic wr, input logic [3:0] wen,
                                         input logic [2:0] ext_op);
    logic [1:0] sz;
    if (wr) begin
      case (wen)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
        4'b0011, 4'b1100:                   sz = 2'd1;
        default:                            sz = 2'd2;
      endcase
    end else begin
      if (ext_op[2])      sz = 2'd2;
      else if (ext_op[1]) sz = 2'd1;
      else                sz = 2'd0;
    end
    return sz;
  endfunction

  // Replicate the store value across every lane it could land in.
  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {4{w[7:0]}};
      2'd1:    r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half out of the bus word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] off,
                                          input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {24'd0, b};
      3'b010:  r = {{16{h[15]}}, h};
      3'b011:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign req_size   = size_of(req_wr, req_wen, req_ext_op);
  assign suppressed = req_wr & (req_wen == 4'b0000);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ~suppressed &
                      (((req_size == 2'd1) & req_addr[0]) |
                       ((req_size == 2'd2) & (req_addr[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode.
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    data_req  = 1'b0;
    accept    = 1'b0;
    launch    = 1'b0;
    complete  = 1'b0;
    kill_now  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid & ~flush;
        launch    = accept & ~suppressed & ~misaligned;
        if (launch) state_d = S_ADDR;
      end
      S_ADDR: begin
        data_req = 1'b1;
        if (data_addr_ok) begin
          // Address already on the bus: a flush can only mute the result.
          kill_now = flush;
          complete = data_data_ok;
          if (data_data_ok) state_d = S_IDLE;
          else              state_d = S_DATA;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        kill_now = flush;
        complete = data_data_ok;
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall      = (state_q != S_IDLE);
  assign data_wr    = data_req & wr_q;
  assign data_size  = data_req ? size_q : 2'd0;
  assign data_addr  = data_req ? addr_q : 32'd0;
  assign data_wstrb = data_wr ? wen_q : 4'd0;
  assign data_wdata = data_wr ? wdata_q : 32'd0;

  // Latch the accepted operation and register the load response.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wen_q      <= 4'd0;
      ext_op_q   <= 3'd0;
      dst_q      <= 5'd0;
      size_q     <= 2'd0;
      wr_q       <= 1'b0;
      killed_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_dst   <= 5'd0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= replicate(req_size, req_wdata);
        wen_q    <= req_wen;
        ext_op_q <= req_ext_op;
        dst_q    <= req_dst;
        size_q   <= req_size;
        wr_q     <= req_wr;
        killed_q <= 1'b0;
      end else if (kill_now) begin
        killed_q <= 1'b1;
      end
      if (complete & ~wr_q & ~killed_q & ~flush) begin
        resp_valid <= 1'b1;
        resp_rdata <= extract(data_rdata, addr_q[1:0], ext_op_q);
        resp_dst   <= dst_q;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic        adel_q, ades_q;
  logic [31:0] bad_vaddr_q;

  // One-cycle address-error pulse for a misaligned access seen at accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      bad_vaddr_q <= 32'd0;
    end else begin
      adel_q <= accept & misaligned & ~req_wr;
      ades_q <= accept & misaligned & req_wr;
      if (accept & misaligned) bad_vaddr_q <= req_addr;
    end
  end

  assign adel      = adel_q;
  assign ades      = ades_q;
  assign bad_vaddr = bad_vaddr_q;
`else
  assign adel      = 1'b0;
  assign ades      = 1'b0;
  assign bad_vaddr = 32'd0;
`endif

endmodule
